// File: rtl/cache_axi_master.sv
// cache_axi_master: turns cache line refill / write-back requests into single
// AXI3 INCR bursts of LINE_WORDS 32-bit beats, one transaction at a time.
module cache_axi_master #(
   parameter logic [3:0] AXI_ID     = 4'd0,
   parameter int         LINE_WORDS = 4
) (
   input  logic        aclk,
   input  logic        aresetn,
   // cache side
   input  logic        en,
   input  logic        wen,
   input  logic [31:0] addr,
   input  logic [31:0] write_data,
   output logic [31:0] read_data,
   output logic        addr_ok,
   output logic        data_ok,
   output logic        burst_ok,
   // AR channel
   output logic [3:0]  arid,
   output logic [31:0] araddr,
   output logic [3:0]  arlen,
   output logic [2:0]  arsize,
   output logic [1:0]  arburst,
   output logic [1:0]  arlock,
   output logic [3:0]  arcache,
   output logic [2:0]  arprot,
   output logic        arvalid,
   input  logic        arready,
   // R channel
   input  logic [3:0]  rid,
   input  logic [31:0] rdata,
   input  logic [1:0]  rresp,
   input  logic        rlast,
   input  logic        rvalid,
   output logic        rready,
   // AW channel
   output logic [3:0]  awid,
   output logic [31:0] awaddr,
   output logic [3:0]  awlen,
   output logic [2:0]  awsize,
   output logic [1:0]  awburst,
   output logic [1:0]  awlock,
   output logic [3:0]  awcache,
   output logic [2:0]  awprot,
   output logic        awvalid,
   input  logic        awready,
   // W channel
   output logic [3:0]  wid,
   output logic [31:0] wdata,
   output logic [3:0]  wstrb,
   output logic        wlast,
   output logic        wvalid,
   input  logic        wready,
   // B channel
   input  logic [3:0]  bid,
   input  logic [1:0]  bresp,
   input  logic        bvalid,
   output logic        bready
);

   localparam int               CNT_W     = $clog2(LINE_WORDS);
   localparam int               OFF_W     = CNT_W + 2;
   localparam logic [3:0]       BURST_LEN = 4'(LINE_WORDS - 1);
   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(LINE_WORDS - 1);

   typedef enum logic [2:0] {IDLE, AR, R, AW, W, B} state_t;

   state_t           state;
   logic [31:0]      base;
   logic [CNT_W-1:0] cnt;

   // Response IDs/status and the in-line address offset carry no information
   // for this master; there is no error path.
   logic unused_inputs;
   assign unused_inputs = ^{rid, rresp, bid, bresp, addr[OFF_W-1:0]};

   // Transaction sequencer: state, line base, beat counter and the registered
   // valid/ready handshake outputs, all moving together.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state   <= IDLE;
         base    <= '0;
         cnt     <= '0;
         arvalid <= 1'b0;
         rready  <= 1'b0;
         awvalid <= 1'b0;
         wvalid  <= 1'b0;
         bready  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (en) begin
                  base <= {addr[31:OFF_W], {OFF_W{1'b0}}};
                  if (wen) begin
                     state   <= AW;
                     awvalid <= 1'b1;
                  end else begin
                     state   <= AR;
                     arvalid <= 1'b1;
                  end
               end
            end
            AR: begin
               if (arready) begin
                  arvalid <= 1'b0;
                  rready  <= 1'b1;
                  state   <= R;
               end
            end
            R: begin
               if (rvalid && rlast) begin
                  rready <= 1'b0;
                  state  <= IDLE;
               end
            end
            AW: begin
               if (awready) begin
                  awvalid <= 1'b0;
                  wvalid  <= 1'b1;
                  cnt     <= '0;
                  state   <= W;
               end
            end
            W: begin
               if (wready) begin
                  cnt <= cnt + 1'b1;
                  if (cnt == LAST_BEAT) begin
                     wvalid <= 1'b0;
                     bready <= 1'b1;
                     state  <= B;
                  end
               end
            end
            B: begin
               if (bvalid) begin
                  bready <= 1'b0;
                  state  <= IDLE;
               end
            end
            default: begin
               state   <= IDLE;
               arvalid <= 1'b0;
               rready  <= 1'b0;
               awvalid <= 1'b0;
               wvalid  <= 1'b0;
               bready  <= 1'b0;
            end
         endcase
      end
   end

   // Cache-side strobes follow the slave handshakes within the same cycle.
   always_comb begin
      addr_ok  = (state == IDLE);
      data_ok  = ((state == R) && rvalid) || ((state == W) && wready);
      burst_ok = ((state == R) && rvalid && rlast) || ((state == B) && bvalid);
      wlast    = (state == W) && (cnt == LAST_BEAT);
   end

   // Data passes straight through; the cache owns word sequencing.
   assign read_data = rdata;
   assign wdata     = write_data;

   // Address and fixed burst attributes: one full line, 4-byte beats, INCR.
   assign arid    = AXI_ID;
   assign araddr  = base;
   assign arlen   = BURST_LEN;
   assign arsize  = 3'b010;
   assign arburst = 2'b01;
   assign arlock  = 2'b00;
   assign arcache = 4'h0;
   assign arprot  = 3'b000;

   assign awid    = AXI_ID;
   assign awaddr  = base;
   assign awlen   = BURST_LEN;
   assign awsize  = 3'b010;
   assign awburst = 2'b01;
   assign awlock  = 2'b00;
   assign awcache = 4'h0;
   assign awprot  = 3'b000;

   assign wid     = AXI_ID;
   assign wstrb   = 4'hF;

endmodule

// File: tb/tb_cache_axi_master.sv
// tb_cache_axi_master: table-driven and randomized transactions against a
// line-level model of the cache/AXI handshakes.
module tb_cache_axi_master;

   localparam int          LW       = 4;
   localparam logic [31:0] OFF_MASK = 32'(LW * 4 - 1);
   localparam logic [31:0] FIXED    = {3'b010, 2'b01, 2'b00, 4'h0, 3'b000,
                                       3'b010, 2'b01, 2'b00, 4'h0, 3'b000, 4'hF};

   logic        aclk = 1'b0;
   logic        aresetn;
   logic        en, wen;
   logic [31:0] addr, write_data, read_data;
   logic        addr_ok, data_ok, burst_ok;
   logic [3:0]  arid, arlen, arcache, awid, awlen, awcache, wid, wstrb, rid, bid;
   logic [31:0] araddr, awaddr, wdata, rdata;
   logic [2:0]  arsize, arprot, awsize, awprot;
   logic [1:0]  arburst, arlock, awburst, awlock, rresp, bresp;
   logic        arvalid, arready, rlast, rvalid, rready;
   logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;

   cache_axi_master #(.AXI_ID(4'd0), .LINE_WORDS(LW)) dut (
      .aclk(aclk), .aresetn(aresetn),
      .en(en), .wen(wen), .addr(addr), .write_data(write_data),
      .read_data(read_data), .addr_ok(addr_ok), .data_ok(data_ok), .burst_ok(burst_ok),
      .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
      .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
      .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
      .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
      .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
      .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
      .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
   );

   always #5 aclk = ~aclk;

   int cyc = 0;
   always @(posedge aclk) cyc++;

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, req, $time);
      end
   endtask

   task automatic chkb(input string name, input logic act, input logic req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%b required=%b (t=%0t)", name, act, req, $time);
      end
   endtask

   task automatic tick();
      @(posedge aclk);
      #1;
   endtask

   // Random activity on every slave input; callers override the owning channel.
   task automatic noise();
      arready = 1'($urandom_range(0, 1));
      rvalid  = 1'($urandom_range(0, 1));
      rlast   = 1'($urandom_range(0, 1));
      rdata   = $urandom;
      rid     = 4'($urandom);
      rresp   = 2'($urandom);
      awready = 1'($urandom_range(0, 1));
      wready  = 1'($urandom_range(0, 1));
      bvalid  = 1'($urandom_range(0, 1));
      bid     = 4'($urandom);
      bresp   = 2'($urandom);
   endtask

   task automatic quiet();
      arready = 1'b0; rvalid = 1'b0; rlast = 1'b0; rdata = '0; rid = '0; rresp = '0;
      awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bid = '0; bresp = '0;
   endtask

   // mode 0: always ready/valid, 1: toggle starting with 1, 2: random
   function automatic logic pick(input int mode, input int k);
      if (mode == 0) return 1'b1;
      if (mode == 1) return (k % 2) == 0;
      return $urandom_range(0, 99) < 60;
   endfunction

   task automatic run_txn(input logic w, input logic [31:0] a, input logic [31:0] exp_base,
                          input int ar_wait, input int mode, input logic fixed, input logic timing);
      logic [31:0] words [LW];
      int beat, k, bwait, t_acc, t_first, t_burst;
      bit done;
      for (int i = 0; i < LW; i++)
         words[i] = fixed ? (w ? 32'(17 * (i + 1)) : 32'(160 + i)) : $urandom;
      t_first = -1;
      t_burst = -1;
      // accept cycle
      noise();
      en = 1'b1; wen = w; addr = a; write_data = words[0];
      #2;
      chkb("accept_addr_ok", addr_ok, 1'b1);
      t_acc = cyc;
      tick();
      // address phase
      for (int j = 0; j <= ar_wait; j++) begin
         noise();
         en = 1'($urandom_range(0, 1)); wen = 1'($urandom_range(0, 1)); addr = $urandom;
         if (w) awready = (j == ar_wait); else arready = (j == ar_wait);
         #2;
         chkb("addr_valid", w ? awvalid : arvalid, 1'b1);
         chkb("other_addr_valid", w ? arvalid : awvalid, 1'b0);
         chk("line_base", w ? awaddr : araddr, exp_base);
         chk("burst_len", 32'(w ? awlen : arlen), 32'(LW - 1));
         chk("addr_phase_idle", {27'd0, addr_ok, data_ok, burst_ok, rready, wvalid | bready}, 32'd0);
         if (j == 0) begin
            chk("fixed_fields", {arsize, arburst, arlock, arcache, arprot,
                                 awsize, awburst, awlock, awcache, awprot, wstrb}, FIXED);
            chk("ids", {20'd0, arid, awid, wid}, 32'd0);
         end
         tick();
      end
      // data phase
      beat = 0;
      k = 0;
      while (beat < LW && k < 200) begin
         noise();
         en = 1'($urandom_range(0, 1));
         if (!w) begin
            rvalid = pick(mode, k);
            rdata  = words[beat];
            rlast  = rvalid && (beat == LW - 1);
            #2;
            chkb("rready", rready, 1'b1);
            chkb("r_data_ok", data_ok, rvalid);
            chkb("r_burst_ok", burst_ok, rlast);
            chkb("r_addr_ok", addr_ok, 1'b0);
            if (rvalid) begin
               chk("read_data", read_data, words[beat]);
               if (t_first < 0) t_first = cyc;
               if (rlast) t_burst = cyc;
               beat++;
            end
         end else begin
            wready     = pick(mode, k);
            write_data = words[beat];
            #2;
            chkb("wvalid", wvalid, 1'b1);
            chk("wdata", wdata, words[beat]);
            chkb("wlast", wlast, beat == LW - 1);
            chkb("w_data_ok", data_ok, wready);
            chkb("w_burst_ok", burst_ok, 1'b0);
            chkb("w_bready", bready, 1'b0);
            if (wready) beat++;
         end
         k++;
         tick();
      end
      if (beat < LW) chk("data_timeout", 32'(beat), 32'(LW));
      // write response phase
      if (w) begin
         bwait = (mode == 0) ? 0 : $urandom_range(0, 3);
         done = 0;
         k = 0;
         while (!done && k < 200) begin
            noise();
            en = 1'($urandom_range(0, 1));
            bvalid = (k >= bwait);
            #2;
            chkb("bready", bready, 1'b1);
            chkb("b_burst_ok", burst_ok, bvalid);
            chkb("b_data_ok", data_ok, 1'b0);
            chkb("b_wvalid", wvalid, 1'b0);
            if (bvalid) done = 1;
            k++;
            tick();
         end
         if (!done) chkb("b_timeout", 1'b0, 1'b1);
      end
      // back in idle: everything quiet regardless of slave inputs
      noise();
      en = 1'b0;
      #2;
      chkb("post_addr_ok", addr_ok, 1'b1);
      chk("post_quiet", {25'd0, arvalid, rready, awvalid, wvalid, bready, data_ok, burst_ok}, 32'd0);
      if (timing) begin
         chk("lat_first_data", 32'(t_first - t_acc), 32'd2);
         chk("lat_burst", 32'(t_burst - t_acc), 32'(LW + 1));
      end
   endtask

   typedef struct {
      logic        w;
      logic [31:0] a;
      logic [31:0] base;
      int          ar_wait;
      int          mode;
      logic        fixed;
      logic        timing;
   } vec_t;

   vec_t vecs [6];

   initial begin
      logic        rw;
      logic [31:0] ra;
      vecs[0] = '{1'b0, 32'h1FC0_0014, 32'h1FC0_0010, 0, 0, 1'b1, 1'b1};
      vecs[1] = '{1'b1, 32'h8000_0100, 32'h8000_0100, 0, 1, 1'b1, 1'b0};
      vecs[2] = '{1'b0, 32'h0000_003C, 32'h0000_0030, 5, 0, 1'b0, 1'b0};
      vecs[3] = '{1'b0, 32'hDEAD_BEEF, 32'hDEAD_BEE0, 2, 2, 1'b0, 1'b0};
      vecs[4] = '{1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFF0, 3, 2, 1'b0, 1'b0};
      vecs[5] = '{1'b1, 32'h0000_000F, 32'h0000_0000, 0, 0, 1'b0, 1'b0};

      // reset state
      aresetn = 1'b0;
      en = 1'b0; wen = 1'b0; addr = '0; write_data = '0;
      noise();
      #3;
      chkb("rst_addr_ok", addr_ok, 1'b1);
      chk("rst_quiet", {25'd0, arvalid, rready, awvalid, wvalid, bready, data_ok, burst_ok}, 32'd0);
      chk("rst_base", araddr, 32'd0);
      chkb("rst_wlast", wlast, 1'b0);
      tick();
      tick();
      aresetn = 1'b1;

      for (int i = 0; i < 6; i++)
         run_txn(vecs[i].w, vecs[i].a, vecs[i].base, vecs[i].ar_wait,
                 vecs[i].mode, vecs[i].fixed, vecs[i].timing);

      for (int i = 0; i < 16; i++) begin
         rw = 1'($urandom_range(0, 1));
         ra = $urandom;
         run_txn(rw, ra, ra & ~OFF_MASK, $urandom_range(0, 4), 2, 1'b0, 1'b0);
      end

      // reset asserted during the second write beat
      tick();
      quiet();
      en = 1'b1; wen = 1'b1; addr = 32'h4000_0048; write_data = 32'h1111_0000;
      #2;
      chkb("mr_accept", addr_ok, 1'b1);
      tick();
      en = 1'b0; awready = 1'b1;
      #2;
      chkb("mr_awvalid", awvalid, 1'b1);
      chk("mr_awaddr", awaddr, 32'h4000_0040);
      tick();
      awready = 1'b0; wready = 1'b1;
      #2;
      chkb("mr_beat0", data_ok, 1'b1);
      tick();
      write_data = 32'h2222_0001;
      #2;
      chk("mr_beat1_wdata", wdata, 32'h2222_0001);
      chkb("mr_beat1_wvalid", wvalid, 1'b1);
      aresetn = 1'b0;
      #1;
      chkb("mr_addr_ok", addr_ok, 1'b1);
      chk("mr_quiet", {24'd0, arvalid, rready, awvalid, wvalid, bready, wlast, data_ok, burst_ok}, 32'd0);
      chk("mr_awaddr_cleared", awaddr, 32'd0);
      tick();
      tick();
      aresetn = 1'b1;
      wready = 1'b0;
      run_txn(1'b0, 32'h1FC0_0024, 32'h1FC0_0020, 0, 0, 1'b1, 1'b1);
      run_txn(1'b1, 32'h0000_1234, 32'h0000_1230, 1, 1, 1'b1, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog simulation did not complete");
      $fatal(1, "watchdog");
   end

endmodule
